// File: rtl/geig_multi_integrator.sv
// N-channel Geiger pulse integrator: windowed counts plus timestamp snapshots into an FWFT record FIFO.
// Define GEIG_DEADTIME_EN to build the per-channel dead-time filter.
module geig_multi_integrator #(
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 14,
   parameter int TS_W         = 24,
   parameter int DEPTH        = 8,
   parameter int DEADTIME_CYC = 50
) (
   input  logic                            CLK_1MHZ,
   input  logic                            RESET,
   input  logic                            ENABLE,
   input  logic                            TICK_10HZ,
   input  logic [7:0]                      WINDOW_TICKS,
   input  logic [TS_W-1:0]                 TIMESTAMP,
   input  logic [NUM_CH-1:0]               GSTREAM,
   output logic                            REC_VALID,
   input  logic                            REC_READY,
   output logic [TS_W+NUM_CH*CNT_W-1:0]    REC_DATA,
   output logic [$clog2(DEPTH):0]          REC_LEVEL,
   output logic [NUM_CH-1:0]               SAT_FLAGS,
   output logic [7:0]                      DROP_CNT
);

   localparam int               REC_W    = TS_W + NUM_CH*CNT_W;
   localparam int               AW       = $clog2(DEPTH);
   localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic {ST_ARM, ST_INTEG} state_t;

   if (NUM_CH < 1 || NUM_CH > 8 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEADTIME_CYC < 1)
   begin : g_param_check
      $error("geig_multi_integrator: illegal parameter set");
   end

   logic [NUM_CH-1:0] sync1_q, sync2_q, prev_q, pulse, count_en;

   always_ff @(posedge CLK_1MHZ) begin
      if (RESET) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= GSTREAM;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign pulse = sync2_q & ~prev_q;

`ifdef GEIG_DEADTIME_EN
   localparam int DT_W = $clog2(DEADTIME_CYC + 1);
   logic [NUM_CH-1:0][DT_W-1:0] dt_q, dt_d;

   always_comb begin
      dt_d     = dt_q;
      count_en = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         count_en[i] = pulse[i] && (dt_q[i] == '0);
         if (!ENABLE)
            dt_d[i] = '0;
         else if (count_en[i])
            dt_d[i] = DT_W'(DEADTIME_CYC);
         else if (dt_q[i] != '0)
            dt_d[i] = dt_q[i] - DT_W'(1);
      end
   end

   always_ff @(posedge CLK_1MHZ) begin
      if (RESET) dt_q <= '0;
      else       dt_q <= dt_d;
   end
`else
   assign count_en = pulse;
`endif

   state_t                        state_q, state_d;
   logic [7:0]                    tick_q, tick_d, win_q, win_d, win_eff;
   logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic                          snap, load_new, inc, win_end;

   assign win_eff = (WINDOW_TICKS == 8'd0) ? 8'd1 : WINDOW_TICKS;
   assign win_end = ({1'b0, tick_q} + 9'd1) == {1'b0, win_q};

   // An edge landing on a window boundary seeds the new window's count.
   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      win_d    = win_q;
      cnt_d    = cnt_q;
      snap     = 1'b0;
      load_new = 1'b0;
      inc      = 1'b0;
      case (state_q)
         ST_ARM: begin
            if (ENABLE && TICK_10HZ) begin
               state_d  = ST_INTEG;
               load_new = 1'b1;
            end
         end
         ST_INTEG: begin
            if (!ENABLE) begin
               state_d = ST_ARM;
            end else if (TICK_10HZ && win_end) begin
               snap     = 1'b1;
               load_new = 1'b1;
            end else begin
               inc = 1'b1;
               if (TICK_10HZ) tick_d = tick_q + 8'd1;
            end
         end
         default: state_d = ST_ARM;
      endcase
      if (load_new) begin
         tick_d = '0;
         win_d  = win_eff;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (load_new)
            cnt_d[i] = CNT_W'(count_en[i]);
         else if (!inc)
            cnt_d[i] = '0;
         else if (count_en[i] && (cnt_q[i] != CNT_MAX))
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK_1MHZ) begin
      if (RESET) begin
         state_q <= ST_ARM;
         tick_q  <= '0;
         win_q   <= 8'd1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
      end
   end

   logic [REC_W-1:0]  mem_q [DEPTH];
   logic [NUM_CH-1:0] satm_q [DEPTH];
   logic [AW-1:0]     wr_q, rd_q;
   logic [AW:0]       lvl_q;
   logic [7:0]        drop_q;
   logic [REC_W-1:0]  snap_rec;
   logic [NUM_CH-1:0] snap_sat;
   logic              full, pop, push_ok, drop;

   always_comb begin
      snap_sat = '0;
      for (int i = 0; i < NUM_CH; i++)
         snap_sat[i] = (cnt_q[i] == CNT_MAX);
   end

   assign snap_rec = {TIMESTAMP, cnt_q};
   assign full     = (lvl_q == FULL_LVL);
   assign pop      = REC_VALID && REC_READY;
   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign push_ok  = snap && (!full || pop);
   assign drop     = snap && full && !pop;

   always_ff @(posedge CLK_1MHZ) begin
      if (RESET) begin
         wr_q   <= '0;
         rd_q   <= '0;
         lvl_q  <= '0;
         drop_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + AW'(1);
         if (pop)     rd_q <= rd_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   lvl_q <= lvl_q + (AW+1)'(1);
            2'b01:   lvl_q <= lvl_q - (AW+1)'(1);
            default: lvl_q <= lvl_q;
         endcase
         if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
      end
   end

   always_ff @(posedge CLK_1MHZ) begin
      if (push_ok) begin
         mem_q[wr_q]  <= snap_rec;
         satm_q[wr_q] <= snap_sat;
      end
   end

   assign REC_VALID = (lvl_q != '0);
   assign REC_DATA  = REC_VALID ? mem_q[rd_q] : '0;
   assign SAT_FLAGS = REC_VALID ? satm_q[rd_q] : '0;
   assign REC_LEVEL = lvl_q;
   assign DROP_CNT  = drop_q;

endmodule

// File: tb/tb_geig_multi_integrator.sv
// Bench for geig_multi_integrator: directed scenarios plus randomized traffic against a window/record model.
module tb_geig_multi_integrator;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 4;
   localparam int TS_W   = 24;
   localparam int DEPTH  = 8;
   localparam int DT_CYC = 50;
   localparam int REC_W  = TS_W + NUM_CH*CNT_W;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk;
   logic              rst, en, tick, rdy;
   logic [7:0]        win;
   logic [TS_W-1:0]   ts;
   logic [NUM_CH-1:0] gs;
   logic              rec_valid;
   logic [REC_W-1:0]  rec_data;
   logic [3:0]        rec_level;
   logic [NUM_CH-1:0] sat;
   logic [7:0]        drop;

   geig_multi_integrator #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH), .DEADTIME_CYC(DT_CYC)
   ) dut (
      .CLK_1MHZ(clk), .RESET(rst), .ENABLE(en), .TICK_10HZ(tick), .WINDOW_TICKS(win),
      .TIMESTAMP(ts), .GSTREAM(gs), .REC_VALID(rec_valid), .REC_READY(rdy),
      .REC_DATA(rec_data), .REC_LEVEL(rec_level), .SAT_FLAGS(sat), .DROP_CNT(drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [REC_W-1:0]  data;
      logic [NUM_CH-1:0] sat;
   } rec_t;

   rec_t              m_q[$];
   bit                m_integ;
   int                m_tc, m_win, m_drop, m_cyc;
   int                m_raw[NUM_CH];
   int                m_last[NUM_CH];
   logic [NUM_CH-1:0] g1, g2, g3;
   int                n_cmp, n_bad;
   bit                ts_auto;
   int                ta, tb;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: a rising edge reaches the counters two edges after it is first sampled.
   task automatic model_edge();
      logic [NUM_CH-1:0] p;
      rec_t              r;
      m_cyc++;
      if (rst) begin
         m_integ = 0; m_tc = 0; m_win = 1; m_drop = 0;
         m_q.delete();
         g1 = '0; g2 = '0; g3 = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_raw[i]  = 0;
            m_last[i] = -1000;
         end
         return;
      end
      p  = g2 & ~g3;
      g3 = g2; g2 = g1; g1 = gs;
`ifdef GEIG_DEADTIME_EN
      for (int i = 0; i < NUM_CH; i++) begin
         if (p[i] && (m_cyc - m_last[i] <= DT_CYC)) p[i] = 1'b0;
         if (!en)       m_last[i] = -1000;
         else if (p[i]) m_last[i] = m_cyc;
      end
`endif
      if ((m_q.size() != 0) && rdy) void'(m_q.pop_front());
      if (!m_integ) begin
         if (en && tick) begin
            m_integ = 1; m_tc = 0;
            m_win = (win == 8'd0) ? 1 : int'(win);
            for (int i = 0; i < NUM_CH; i++) m_raw[i] = int'(p[i]);
         end else begin
            for (int i = 0; i < NUM_CH; i++) m_raw[i] = 0;
         end
      end else if (!en) begin
         m_integ = 0;
         for (int i = 0; i < NUM_CH; i++) m_raw[i] = 0;
      end else if (tick && (m_tc + 1 == m_win)) begin
         r.data = '0;
         r.sat  = '0;
         r.data[REC_W-1 -: TS_W] = ts;
         for (int i = 0; i < NUM_CH; i++) begin
            r.data[i*CNT_W +: CNT_W] = CNT_W'((m_raw[i] > CMAX) ? CMAX : m_raw[i]);
            r.sat[i] = (m_raw[i] >= CMAX);
            m_raw[i] = int'(p[i]);
         end
         if (m_q.size() == DEPTH) begin
            if (m_drop < 255) m_drop++;
         end else begin
            m_q.push_back(r);
         end
         m_tc = 0;
         m_win = (win == 8'd0) ? 1 : int'(win);
      end else begin
         if (tick) m_tc++;
         for (int i = 0; i < NUM_CH; i++) m_raw[i] += int'(p[i]);
      end
   endtask

   task automatic check_all();
      logic              ev;
      logic [REC_W-1:0]  ed;
      logic [NUM_CH-1:0] es;
      ev = (m_q.size() != 0);
      ed = ev ? m_q[0].data : '0;
      es = ev ? m_q[0].sat : '0;
      chk("valid", 64'(rec_valid), 64'(ev));
      chk("level", 64'(rec_level), 64'(m_q.size()));
      chk("drop",  64'(drop), 64'(m_drop));
      chk("data",  64'(rec_data), 64'(ed));
      chk("sat",   64'(sat), 64'(es));
   endtask

   task automatic step();
      if (ts_auto) ts = ts + 1'b1;
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic pop1();
      rdy = 1'b1;
      step();
      rdy = 1'b0;
   endtask

   task automatic pulses(input int ch, input int num, input int hi, input int lo);
      repeat (num) begin
         gs[ch] = 1'b1;
         idle(hi);
         gs[ch] = 1'b0;
         idle(lo);
      end
   endtask

   task automatic rnd_cycle(input int per);
      for (int i = 0; i < NUM_CH; i++)
         if ($urandom_range(3) == 0) gs[i] = ~gs[i];
      rdy  = ($urandom_range(2) != 0);
      tick = ($urandom_range(per - 1) == 0);
      ts   = TS_W'($urandom);
      step();
      tick = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; m_cyc = 0; ts_auto = 1;
      rst = 1'b1; en = 1'b0; tick = 1'b0; rdy = 1'b0; win = 8'd1; ts = '0; gs = '0;

      // Reset state
      do_reset();
      chk("rst_valid", 64'(rec_valid), 64'd0);
      chk("rst_drop", 64'(drop), 64'd0);

      // Idle windows of one tick: first partial window is discarded
      en = 1'b1; win = 8'd1;
      idle(3); do_tick(); idle(9); do_tick(); ta = int'(ts); idle(9); do_tick(); tb = int'(ts); idle(2);
      chk("t1_level", 64'(rec_level), 64'd2);
      chk("t1_counts", 64'(rec_data[15:0]), 64'd0);
      chk("t1_ts_a", 64'(rec_data[REC_W-1 -: TS_W]), 64'(ta));
      pop1();
      chk("t1_ts_b", 64'(rec_data[REC_W-1 -: TS_W]), 64'(tb));
      pop1();
      chk("t1_empty", 64'(rec_valid), 64'd0);

      // Two-tick window with pulses on ch0 and ch3
      do_reset();
      en = 1'b1; win = 8'd2;
      idle(3); do_tick();
      pulses(0, 7, 5, 5);
      pulses(3, 3, 5, 5);
      idle(5); do_tick(); idle(5);
      chk("t2_pre_valid", 64'(rec_valid), 64'd0);
      do_tick();
      chk("t2_valid", 64'(rec_valid), 64'd1);
      chk("t2_cnt0", 64'(rec_data[3:0]), 64'd7);
      chk("t2_cnt12", 64'(rec_data[11:4]), 64'd0);
      chk("t2_cnt3", 64'(rec_data[15:12]), 64'd3);

      // Saturation on ch1, then a clean window
      pop1();
      pulses(1, 20, 2, 2);
      idle(5); do_tick(); do_tick();
      chk("t3_cnt1", 64'(rec_data[7:4]), 64'd15);
      chk("t3_sat", 64'(sat), 64'b0010);
      pop1();
      do_tick(); do_tick();
      chk("t3_sat_clr", 64'(sat), 64'd0);
      chk("t3_cnt1_clr", 64'(rec_data[7:4]), 64'd0);
      pop1();

      // Overflow: ten windows into an eight-deep FIFO
      do_reset();
      ts_auto = 0; ts = '0; en = 1'b1; win = 8'd1;
      idle(2); do_tick();
      for (int k = 1; k <= 10; k++) begin
         idle(3);
         ts = TS_W'(100 + k);
         do_tick();
      end
      chk("t4_level", 64'(rec_level), 64'd8);
      chk("t4_drop", 64'(drop), 64'd2);
      for (int k = 1; k <= 8; k++) begin
         chk("t4_order_ts", 64'(rec_data[REC_W-1 -: TS_W]), 64'(100 + k));
         pop1();
      end
      chk("t4_empty", 64'(rec_valid), 64'd0);
      ts_auto = 1;

      // Edge coinciding with the snapshot goes to the new window
      do_reset();
      en = 1'b1; win = 8'd1;
      idle(3); do_tick(); idle(5);
      gs[2] = 1'b1; step(); step(); do_tick();
      gs[2] = 1'b0; idle(5); do_tick();
      chk("t5_level", 64'(rec_level), 64'd2);
      chk("t5_old_cnt2", 64'(rec_data[11:8]), 64'd0);
      pop1();
      chk("t5_new_cnt2", 64'(rec_data[11:8]), 64'd1);

      // Reset mid-window with a record pending
      gs[0] = 1'b1; idle(4);
      rst = 1'b1; step(); rst = 1'b0;
      chk("t5_rst_valid", 64'(rec_valid), 64'd0);
      chk("t5_rst_data", 64'(rec_data), 64'd0);
      chk("t5_rst_level", 64'(rec_level), 64'd0);
      chk("t5_rst_sat", 64'(sat), 64'd0);
      gs = '0;

      // Pulses every 20 cycles, ten in one window
      do_reset();
      en = 1'b1; win = 8'd1;
      idle(2); do_tick();
      pulses(0, 10, 2, 18);
      idle(5); do_tick();
`ifdef GEIG_DEADTIME_EN
      chk("t6_deadtime_cnt", 64'(rec_data[3:0]), 64'd4);
`else
      chk("t6_cnt", 64'(rec_data[3:0]), 64'd10);
`endif
      pop1();

      // Drop counter saturation
      do_reset();
      en = 1'b1; win = 8'd1; tick = 1'b1;
      idle(300);
      tick = 1'b0;
      chk("drop_sat", 64'(drop), 64'd255);
      chk("drop_level", 64'(rec_level), 64'd8);

      // Randomized traffic
      do_reset();
      ts_auto = 0;
      for (int blk = 0; blk < 40; blk++) begin
         int per;
         win = 8'($urandom_range(3));
         en  = ($urandom_range(7) != 0);
         per = 2 + int'($urandom_range(30));
         if ($urandom_range(15) == 0) begin
            rst = 1'b1; step(); rst = 1'b0;
         end
         repeat (150) rnd_cycle(per);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
